mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Arbitrates the single PDP-8 memory port between two requesters: the instruction fetch path (read-only) and the execution unit (read/write).
- Sits between those units and the memory model. Owns all memory-side request strobes and returns read data to the winning requester.
- Fixed priority favours the execution unit, with a starvation guard for fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive exec grants, made while fetch_req is pending, after which fetch is forced to win. Legal range 1..15.
- ADDR_W, `ADDR_WIDTH (12): address width, from pdp8_pkg.
- DATA_W, `DATA_WIDTH (12): data width, from pdp8_pkg.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch read request; held until fetch_gnt.
- fetch_addr  in  ADDR_W  fetch read address; stable while fetch_req is high.
- fetch_gnt  out  1  one-cycle pulse: fetch request accepted.
- fetch_rvalid  out  1  one-cycle pulse: fetch_rdata is valid.
- fetch_rdata  out  DATA_W  read data for fetch.
- exec_req  in  1  exec request; held until exec_gnt.
- exec_we  in  1  1 = write, 0 = read; stable with exec_req.
- exec_addr  in  ADDR_W  exec address.
- exec_wdata  in  DATA_W  exec write data.
- exec_gnt  out  1  one-cycle pulse: exec request accepted.
- exec_rvalid  out  1  one-cycle pulse: exec_rdata is valid (reads only).
- exec_rdata  out  DATA_W  read data for exec.
- mem_rd_req  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_W  memory read data; valid the cycle after mem_rd_req.
- mem_wr_req  out  1  memory write strobe.
- mem_wr_addr  out  ADDR_W  memory write address.
- mem_wr_data  out  DATA_W  memory write data.

Behaviour:
- Reset: FSM goes to IDLE. All gnt, rvalid, mem_rd_req and mem_wr_req are 0. Addresses, data and rdata outputs are 0. Starvation counter is 0.
- Reset mid-operation aborts any in-flight read; no rvalid is produced for it.
- FSM states:
  - IDLE: arbitrate. If any request is pending, go to GRANT; otherwise stay in IDLE.
  - GRANT (1 cycle): winner's gnt = 1. The matching mem_rd_req or mem_wr_req = 1, with address/data taken from registers latched at the arbitration edge. Next state is RDATA for a read, IDLE for a write. Requests are not sampled in GRANT.
  - RDATA (1 cycle): winner's rvalid = 1, and its rdata = mem_rd_data passed through combinationally. The loser's rdata holds its previous value. Arbitration also happens here: go to GRANT if a request is pending, else IDLE.
- Latency, measured from the first cycle req is high in IDLE:
  - read: gnt at +1, rvalid at +2;
  - write: gnt at +1, memory written at the end of +1.
- Throughput: back-to-back reads every 2 cycles; back-to-back writes every 2 cycles.
- Handshake: a requester drops req, or presents a new request, in the cycle after gnt. A req still high in the cycle after gnt is treated as a new request.
- Arbitration rule: exec wins over fetch, except when the starvation counter equals STARVE_LIMIT and fetch_req = 1; then fetch wins.
- Starvation counter:
  - increments (saturating at STARVE_LIMIT) on each exec grant made while fetch_req = 1;
  - clears on a fetch grant, or on any arbitration edge where fetch_req = 0.
- Simultaneous requests: only one grant per GRANT cycle. The loser keeps req high and is reconsidered at the next arbitration edge.
- Exactly one of mem_rd_req / mem_wr_req is high in GRANT; both are low in every other state.
- Addresses are passed unmodified; no wrap or translation.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, three extra output ports are added, each a 16-bit saturating counter cleared by reset:
  - stat_exec_gnts: number of exec grants;
  - stat_fetch_gnts: number of fetch grants;
  - stat_starve_forces: number of grants forced by the starvation rule.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Exec write then read: exec_we = 1, exec_addr = 0o200, exec_wdata = 0o1234 → exec_gnt in cycle 1, mem_wr_req = 1 with addr 0o200 and data 0o1234. Then an exec read of 0o200 → exec_rvalid 2 cycles after req, exec_rdata = 0o1234.
- Fetch read alone: fetch_req, fetch_addr = 0o7777 → fetch_gnt at +1, mem_rd_addr = 0o7777, fetch_rvalid at +2, exec_rvalid stays 0.
- Simultaneous request: fetch and exec reads issued in the same cycle → exec granted first, fetch granted at the next GRANT (cycle +3); no overlapping mem strobes.
- Starvation: fetch_req held while exec issues continuous reads, STARVE_LIMIT = 4 → 4 exec grants, then a fetch grant. Counter cleared; exec wins again afterwards.
- Reset during a read: reset asserted in the GRANT cycle → no rvalid next cycle, all outputs 0, FSM in IDLE. A new request after reset completes normally.
- With MEM_ARB_STATS_EN: run the starvation scenario → stat_exec_gnts = 4, stat_fetch_gnts = 1, stat_starve_forces = 1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Handshake and memory-bus bundle for mem_arbiter.
// slave = arbiter view, master = requesters plus memory model view.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

interface mem_arbiter_if #(
    parameter int ADDR_W = `ADDR_WIDTH,
    parameter int DATA_W = `DATA_WIDTH
) ();
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;

    logic              exec_req;
    logic              exec_we;
    logic [ADDR_W-1:0] exec_addr;
    logic [DATA_W-1:0] exec_wdata;
    logic              exec_gnt;
    logic              exec_rvalid;
    logic [DATA_W-1:0] exec_rdata;

    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [DATA_W-1:0] mem_wr_data;

    modport slave (
        input  fetch_req, fetch_addr,
        input  exec_req, exec_we, exec_addr, exec_wdata,
        input  mem_rd_data,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output exec_gnt, exec_rvalid, exec_rdata,
        output mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data
    );

    modport master (
        output fetch_req, fetch_addr,
        output exec_req, exec_we, exec_addr, exec_wdata,
        output mem_rd_data,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  exec_gnt, exec_rvalid, exec_rdata,
        input  mem_rd_req, mem_rd_addr, mem_wr_req, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// PDP-8 memory port arbiter: exec has priority, fetch is forced after STARVE_LIMIT exec wins.
// Define MEM_ARB_STATS_EN to add the stat_* grant counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = `ADDR_WIDTH,
    parameter int DATA_W       = `DATA_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0] stat_exec_gnts,
    output logic [15:0] stat_fetch_gnts,
    output logic [15:0] stat_starve_forces
`endif
);
    typedef enum logic [1:0] {IDLE, GRANT, RDATA} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state;
    logic [3:0]        starve_cnt;
    logic              win_fetch;
    logic              win_read;

    logic              fetch_gnt_q;
    logic              fetch_rvalid_q;
    logic [DATA_W-1:0] fetch_rdata_q;
    logic              exec_gnt_q;
    logic              exec_rvalid_q;
    logic [DATA_W-1:0] exec_rdata_q;
    logic              rd_req_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              wr_req_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              any_req;
    logic              pick_fetch;

    always_comb begin
        any_req    = bus.fetch_req || bus.exec_req;
        pick_fetch = bus.fetch_req && (!bus.exec_req || (starve_cnt == LIMIT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            starve_cnt     <= '0;
            win_fetch      <= 1'b0;
            win_read       <= 1'b0;
            fetch_gnt_q    <= 1'b0;
            fetch_rvalid_q <= 1'b0;
            fetch_rdata_q  <= '0;
            exec_gnt_q     <= 1'b0;
            exec_rvalid_q  <= 1'b0;
            exec_rdata_q   <= '0;
            rd_req_q       <= 1'b0;
            rd_addr_q      <= '0;
            wr_req_q       <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
        end else begin
            fetch_gnt_q    <= 1'b0;
            exec_gnt_q     <= 1'b0;
            fetch_rvalid_q <= 1'b0;
            exec_rvalid_q  <= 1'b0;
            rd_req_q       <= 1'b0;
            wr_req_q       <= 1'b0;

            case (state)
                GRANT: begin
                    if (win_read) begin
                        state          <= RDATA;
                        fetch_rvalid_q <= win_fetch;
                        exec_rvalid_q  <= !win_fetch;
                    end else begin
                        state <= IDLE;
                    end
                end

                IDLE, RDATA: begin
                    // Capture the returning read word so the winner's rdata holds after rvalid.
                    if (state == RDATA) begin
                        if (win_fetch)
                            fetch_rdata_q <= bus.mem_rd_data;
                        else
                            exec_rdata_q  <= bus.mem_rd_data;
                    end

                    if (any_req) begin
                        state     <= GRANT;
                        win_fetch <= pick_fetch;
                        if (pick_fetch) begin
                            fetch_gnt_q <= 1'b1;
                            rd_req_q    <= 1'b1;
                            rd_addr_q   <= bus.fetch_addr;
                            win_read    <= 1'b1;
                            starve_cnt  <= '0;
                        end else begin
                            exec_gnt_q <= 1'b1;
                            win_read   <= !bus.exec_we;
                            if (bus.exec_we) begin
                                wr_req_q  <= 1'b1;
                                wr_addr_q <= bus.exec_addr;
                                wr_data_q <= bus.exec_wdata;
                            end else begin
                                rd_req_q  <= 1'b1;
                                rd_addr_q <= bus.exec_addr;
                            end
                            if (!bus.fetch_req)
                                starve_cnt <= '0;
                            else if (starve_cnt != LIMIT)
                                starve_cnt <= starve_cnt + 1'b1;
                        end
                    end else begin
                        state      <= IDLE;
                        starve_cnt <= '0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Winner's rdata is the memory word itself during rvalid, otherwise the held copy.
    assign bus.fetch_gnt    = fetch_gnt_q;
    assign bus.fetch_rvalid = fetch_rvalid_q;
    assign bus.fetch_rdata  = fetch_rvalid_q ? bus.mem_rd_data : fetch_rdata_q;
    assign bus.exec_gnt     = exec_gnt_q;
    assign bus.exec_rvalid  = exec_rvalid_q;
    assign bus.exec_rdata   = exec_rvalid_q ? bus.mem_rd_data : exec_rdata_q;
    assign bus.mem_rd_req   = rd_req_q;
    assign bus.mem_rd_addr  = rd_addr_q;
    assign bus.mem_wr_req   = wr_req_q;
    assign bus.mem_wr_addr  = wr_addr_q;
    assign bus.mem_wr_data  = wr_data_q;

`ifdef MEM_ARB_STATS_EN
    logic arb_edge;
    logic starve_force;

    always_comb begin
        arb_edge     = (state == IDLE) || (state == RDATA);
        starve_force = bus.fetch_req && bus.exec_req && (starve_cnt == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_exec_gnts     <= '0;
            stat_fetch_gnts    <= '0;
            stat_starve_forces <= '0;
        end else if (arb_edge && any_req) begin
            if (pick_fetch) begin
                if (stat_fetch_gnts != '1)
                    stat_fetch_gnts <= stat_fetch_gnts + 16'd1;
            end else begin
                if (stat_exec_gnts != '1)
                    stat_exec_gnts <= stat_exec_gnts + 16'd1;
            end
            if (starve_force && (stat_starve_forces != '1))
                stat_starve_forces <= stat_starve_forces + 16'd1;
        end
    end
`endif
endmodule
